arb4_rr: RTL and testbench

ARB4_RR -- requirements
Module: arb4_rr

---
 rtl/arb4_rr_pkg.sv | 26 ++
 rtl/arb4_rr_pick.sv | 26 ++
 rtl/arb4_rr.sv | 112 +++++++++++
 tb/tb_arb4_rr.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb4_rr_pkg.sv
// Shared definitions for the 4-way round-robin bus arbiter.
package arb4_rr_pkg;

   // Number of requesters sharing the 16-bit path.
   localparam int unsigned N_REQ = 4;
   // Width of an owner index.
   localparam int unsigned IDX_W = 2;
   // Default select width driven to the shared 4-to-1 mux.
   localparam int unsigned SEL_W = 2;
   // Width of the per-grant beat counter.
   localparam int unsigned CNT_W = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   // One-hot grant vector for a requester index.
   function automatic logic [N_REQ-1:0] onehot4(input logic [IDX_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/arb4_rr_pick.sv
// Round-robin search: first asserted request at or after 'start', wrapping.
module rr_pick4
   import arb4_rr_pkg::*;
(
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] start_i,
   output logic [IDX_W-1:0] winner_o,
   output logic             found_o
);

   // Scan the four positions beginning at start_i; first hit wins.
   always_comb begin
      logic [IDX_W-1:0] idx;
      winner_o = '0;
      found_o  = 1'b0;
      idx      = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         idx = start_i + i[IDX_W-1:0];
         if (!found_o && req_i[idx]) begin
            winner_o = idx;
            found_o  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arb4_rr.sv
// Four-requester round-robin arbiter with a per-grant beat quantum and
// zero-bubble handover between owners.
module arb4_rr
   import arb4_rr_pkg::*;
#(
   parameter int unsigned QUANTUM = 4,
   parameter int unsigned SEL_W   = arb4_rr_pkg::SEL_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       req,
   input  logic [3:0]       last,
   input  logic             ready,
   output logic [3:0]       gnt,
   output logic [SEL_W-1:0] sel,
   output logic             valid,
   output logic             busy
);

   state_e           state_q, state_d;
   logic [N_REQ-1:0] gnt_q,   gnt_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [IDX_W-1:0] ptr_q,   ptr_d;

   logic [IDX_W-1:0] pick_start;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_found;
   logic             owner_req;
   logic             beat;
   logic [CNT_W-1:0] cnt_inc;
   logic             quantum_hit;
   logic             release_c;

   assign owner_req   = req[owner_q];
   assign valid       = (state_q == GRANT) && owner_req;
   assign beat        = valid && ready;
   assign cnt_inc     = cnt_q + 4'd1;
   assign quantum_hit = (cnt_inc == CNT_W'(QUANTUM));
   // A single release flag, so last and quantum expiry on one beat
   // collapse into one handover.
   assign release_c   = (state_q == GRANT) &&
                        (!owner_req || (beat && (last[owner_q] || quantum_hit)));

   // Searching from owner+1 on handover leaves the releasing owner last in
   // line, so it is only re-granted when nobody else is asking.
   assign pick_start  = (state_q == GRANT) ? owner_q + 2'd1 : ptr_q;

   rr_pick4 u_pick (
      .req_i    (req),
      .start_i  (pick_start),
      .winner_o (pick_idx),
      .found_o  (pick_found)
   );

   // Next-state, grant, beat count and pointer update.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE: begin
            gnt_d = '0;
            if (pick_found) begin
               state_d = GRANT;
               gnt_d   = onehot4(pick_idx);
               owner_d = pick_idx;
               cnt_d   = '0;
            end
         end
         GRANT: begin
            if (release_c) begin
               ptr_d = owner_q + 2'd1;
               cnt_d = '0;
               if (pick_found) begin
                  gnt_d   = onehot4(pick_idx);
                  owner_d = pick_idx;
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
               end
            end else if (beat) begin
               cnt_d = cnt_inc;
            end
         end
      endcase
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
      end
   end

   assign gnt  = gnt_q;
   assign sel  = SEL_W'(owner_q);
   assign busy = (state_q == GRANT);

endmodule

// File: tb/tb_arb4_rr.sv
// Self-checking bench for arb4_rr: directed scenarios plus randomized traffic
// compared against a behavioural round-robin model.
module tb_arb4_rr;

   localparam int unsigned Q = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] last;
   logic       ready;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       valid;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   // Behavioural model state: owner (-1 = none), last select, beats, pointer.
   int m_owner;
   int m_sel;
   int m_cnt;
   int m_ptr;

   always #5 clk = ~clk;

   arb4_rr #(.QUANTUM(Q), .SEL_W(2)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .last  (last),
      .ready (ready),
      .gnt   (gnt),
      .sel   (sel),
      .valid (valid),
      .busy  (busy)
   );

   function automatic int rr_find(input logic [3:0] r, input int from);
      for (int k = 0; k < 4; k++) begin
         int j;
         j = (from + k) % 4;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_sel   = 0;
      m_cnt   = 0;
      m_ptr   = 0;
   endtask

   task automatic model_update();
      int w;
      bit b;
      bit rel;
      if (m_owner < 0) begin
         w = rr_find(req, m_ptr);
         if (w >= 0) begin
            m_owner = w;
            m_sel   = w;
            m_cnt   = 0;
         end
      end else begin
         b   = req[m_owner] && ready;
         rel = !req[m_owner] || (b && (last[m_owner] || (m_cnt + 1 == Q)));
         if (b) m_cnt++;
         if (rel) begin
            m_ptr = (m_owner + 1) % 4;
            m_cnt = 0;
            w     = rr_find(req, m_ptr);
            if (w >= 0) begin
               m_owner = w;
               m_sel   = w;
            end else begin
               m_owner = -1;
            end
         end
      end
   endtask

   // Expected {gnt, sel, busy, valid} from the model and current inputs.
   function automatic logic [7:0] exp_vec();
      logic [3:0] g;
      logic       v;
      g = 4'b0000;
      v = 1'b0;
      if (m_owner >= 0) begin
         g = 4'b0001 << m_owner;
         v = req[m_owner];
      end
      return {g, 2'(m_sel), (m_owner >= 0), v};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic apply_reset();
      rst   = 1'b1;
      req   = 4'b0000;
      last  = 4'b0000;
      ready = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
      model_reset();
      tick();
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      req   = 4'b1111;
      last  = 4'b0000;
      ready = 1'b1;
      #2;
      checks++;
      if ({gnt, sel, busy, valid} !== 8'b0000_00_0_0) begin
         failures++;
         $display("FAIL reset_async got=%b exp=%b", {gnt, sel, busy, valid}, 8'b0);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({gnt, sel, busy, valid} !== 8'b0000_00_0_0) begin
         failures++;
         $display("FAIL reset_held got=%b exp=%b", {gnt, sel, busy, valid}, 8'b0);
      end
      #3;
      rst = 1'b0;
      model_reset();
      tick();
      checks++;
      if ({gnt, sel, busy} !== 7'b0001_00_1) begin
         failures++;
         $display("FAIL reset_first_prio got=%b exp=%b", {gnt, sel, busy}, 7'b0001_00_1);
      end
   endtask

   task automatic test_single_last();
      apply_reset();
      req   = 4'b0001;
      ready = 1'b1;
      last  = 4'b0000;
      #1;
      checks++;
      if ({gnt, sel, busy, valid} !== exp_vec()) begin
         failures++;
         $display("FAIL single_idle got=%b exp=%b", {gnt, sel, busy, valid}, exp_vec());
      end
      tick();
      checks++;
      if ({gnt, sel, busy, valid} !== 8'b0001_00_1_1) begin
         failures++;
         $display("FAIL single_grant got=%b exp=%b", {gnt, sel, busy, valid}, 8'b0001_00_1_1);
      end
      tick();
      last = 4'b0001;
      #1;
      checks++;
      if ({gnt, sel, busy, valid} !== exp_vec()) begin
         failures++;
         $display("FAIL single_beat1 got=%b exp=%b", {gnt, sel, busy, valid}, exp_vec());
      end
      tick();
      last = 4'b0000;
      req  = 4'b0000;
      #1;
      checks++;
      if ({gnt, sel, busy, valid} !== exp_vec()) begin
         failures++;
         $display("FAIL single_after_last got=%b exp=%b", {gnt, sel, busy, valid}, exp_vec());
      end
      tick();
      checks++;
      if ({gnt, busy} !== 5'b0000_0) begin
         failures++;
         $display("FAIL single_idle_end got=%b exp=%b", {gnt, busy}, 5'b0);
      end
   endtask

   task automatic test_round_robin();
      apply_reset();
      req   = 4'b1111;
      ready = 1'b1;
      last  = 4'b0000;
      for (int t = 0; t < 20; t++) begin
         logic [3:0] eg;
         tick();
         eg = 4'b0001 << ((t / 4) % 4);
         checks++;
         if (gnt !== eg || {gnt, sel, busy, valid} !== exp_vec()) begin
            failures++;
            $display("FAIL rr_order t=%0d got=%b exp_gnt=%b exp_vec=%b", t,
                     {gnt, sel, busy, valid}, eg, exp_vec());
         end
      end
   endtask

   task automatic test_stall();
      apply_reset();
      req   = 4'b0100;
      ready = 1'b0;
      last  = 4'b0000;
      tick();
      req = 4'b1100;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (gnt !== 4'b0100 || {gnt, sel, busy, valid} !== exp_vec()) begin
            failures++;
            $display("FAIL stall_hold i=%0d got=%b exp_vec=%b", i, {gnt, sel, busy, valid}, exp_vec());
         end
      end
      ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         logic [3:0] eg;
         tick();
         eg = (i < 4) ? 4'b0100 : 4'b1000;
         checks++;
         if (gnt !== eg || {gnt, sel, busy, valid} !== exp_vec()) begin
            failures++;
            $display("FAIL stall_beats i=%0d got=%b exp_gnt=%b", i, {gnt, sel, busy, valid}, eg);
         end
      end
   endtask

   task automatic test_drop_req();
      apply_reset();
      req   = 4'b0010;
      ready = 1'b0;
      last  = 4'b0000;
      tick();
      req = 4'b1010;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (gnt !== 4'b0010) begin
            failures++;
            $display("FAIL drop_hold i=%0d got=%b exp=%b", i, gnt, 4'b0010);
         end
      end
      req = 4'b1000;
      tick();
      checks++;
      if ({gnt, sel, busy, valid} !== 8'b1000_11_1_1) begin
         failures++;
         $display("FAIL drop_handover got=%b exp=%b", {gnt, sel, busy, valid}, 8'b1000_11_1_1);
      end
      // Owner 3 drops with 0 and 2 asking: pointer wraps to 0.
      req = 4'b0101;
      tick();
      checks++;
      if ({gnt, sel} !== 6'b0001_00) begin
         failures++;
         $display("FAIL drop_wrap got=%b exp=%b", {gnt, sel}, 6'b0001_00);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      req   = 4'b1000;
      ready = 1'b1;
      last  = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({gnt, sel, busy, valid} !== exp_vec()) begin
            failures++;
            $display("FAIL rstmid_pre i=%0d got=%b exp=%b", i, {gnt, sel, busy, valid}, exp_vec());
         end
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({gnt, sel, busy, valid} !== 8'b0000_00_0_0) begin
         failures++;
         $display("FAIL rstmid_drop got=%b exp=%b", {gnt, sel, busy, valid}, 8'b0);
      end
      #2;
      rst = 1'b0;
      model_reset();
      req = 4'b1010;
      #1;
      tick();
      checks++;
      if ({gnt, sel, busy} !== 7'b0010_01_1) begin
         failures++;
         $display("FAIL rstmid_regrant got=%b exp=%b", {gnt, sel, busy}, 7'b0010_01_1);
      end
   endtask

   task automatic test_sole_requester();
      apply_reset();
      req   = 4'b0001;
      ready = 1'b1;
      last  = 4'b0000;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if ({gnt, sel, busy, valid} !== 8'b0001_00_1_1 || {gnt, sel, busy, valid} !== exp_vec()) begin
            failures++;
            $display("FAIL sole_regrant i=%0d got=%b exp=%b", i, {gnt, sel, busy, valid}, 8'b0001_00_1_1);
         end
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom);
         last  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
         ready = ($urandom_range(0, 3) != 0);
         #1;
         checks++;
         if ({gnt, sel, busy, valid} !== exp_vec()) begin
            failures++;
            $display("FAIL random_vec i=%0d got=%b exp=%b", i, {gnt, sel, busy, valid}, exp_vec());
         end
         checks++;
         if (!$onehot0(gnt) || (gnt != 4'b0000 && gnt[sel] !== 1'b1)) begin
            failures++;
            $display("FAIL random_onehot i=%0d gnt=%b sel=%0d", i, gnt, sel);
         end
         tick();
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_last();
      test_round_robin();
      test_stall();
      test_drop_req();
      test_reset_mid();
      test_sole_requester();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
